// File: rtl/cpu_pkg.sv
// Shared datapath package: fetch FSM encoding, NOP/halt encodings, PC step.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam int          PC_INC            = 4;

    // Word-align a byte address by clearing its two low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Bubble beats load; with neither it holds.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                bubble_i,
    input  logic [31:0]         instr_i,
    input  logic [PC_WIDTH-1:0] pc4_i,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] pc4_o,
    output logic                valid_o
);

    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc4_q,   pc4_d;
    logic                valid_q, valid_d;

    // Select bubble, new fetch, or hold for the next edge.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble_i) begin
            instr_d = NOP_WORD;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    // Register with asynchronous clear to a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT fetch FSM, IF/ID register.
// Optional stall-cycle performance counter enabled by IF_STAGE_PERF_EN.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]       HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         ifid_instr,
    output logic [PC_WIDTH-1:0] ifid_pc4,
    output logic                ifid_valid,
    output logic                halted
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles
`endif
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] redirect_aligned;
    logic                ld_ifid, bubble_ifid;

    // PC+4 wraps naturally at the register width.
    assign pc_plus4         = pc_q + PC_WIDTH'(PC_INC);
    assign redirect_aligned = redirect_pc & ~PC_WIDTH'(3);

    // Next-state, next-PC and IF/ID control; redirect > flush > stall > fetch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ld_ifid     = 1'b0;
        bubble_ifid = 1'b0;
        case (state_q)
            BOOT: begin
                // One idle cycle lets the memory read at RESET_PC settle.
                bubble_ifid = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (redirect) begin
                    pc_d        = redirect_aligned;
                    bubble_ifid = 1'b1;
                end else if (flush) begin
                    bubble_ifid = 1'b1;
                    if (!stall) pc_d = pc_plus4;
                end else if (!stall) begin
                    ld_ifid = 1'b1;
                    // Halt word still goes to decode; PC parks on it.
                    if (imem_rdata == HALT_WORD) state_d = HALT;
                    else                         pc_d    = pc_plus4;
                end
            end
            HALT: begin
                bubble_ifid = 1'b1;
            end
            default: begin
                state_d     = BOOT;
                bubble_ifid = 1'b1;
            end
        endcase
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifid_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (ld_ifid),
        .bubble_i (bubble_ifid),
        .instr_i  (imem_rdata),
        .pc4_i    (pc_plus4),
        .instr_o  (ifid_instr),
        .pc4_o    (ifid_pc4),
        .valid_o  (ifid_valid)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);

`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_q;

    // Count RUN cycles stalled without a redirect; saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (state_q == RUN && stall && !redirect && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational memory returning addr|0x1000_0000.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_stall_cycles;
`endif

    logic halt_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Instruction memory model; optionally plants the halt word at 0x20.
    always_comb begin
        if (halt_en && imem_addr == 32'h20) imem_rdata = 32'hFFFF_FFFF;
        else                                imem_rdata = imem_addr | 32'h1000_0000;
    end

    if_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid),
        .halted      (halted)
`ifdef IF_STAGE_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 32'h0); end
        total++; if ({ifid_valid, halted} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {ifid_valid, halted}); end
        total++; if ({ifid_instr, ifid_pc4} !== 64'h0) begin bad++; $display("FAIL rst_ifid got=%h exp=0", {ifid_instr, ifid_pc4}); end
        #9 reset = 1'b1;
        tick();  // BOOT
        total++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL boot got v=%b a=%h exp v=0 a=0", ifid_valid, imem_addr); end
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4 || ifid_instr !== 32'h1000_0000) begin bad++; $display("FAIL first got v=%b pc4=%h i=%h exp 1/4/10000000", ifid_valid, ifid_pc4, ifid_instr); end
        tick();
        total++; if (ifid_pc4 !== 32'h8 || ifid_instr !== 32'h1000_0004) begin bad++; $display("FAIL second got pc4=%h i=%h exp 8/10000004", ifid_pc4, ifid_instr); end
        tick();
        total++; if (ifid_pc4 !== 32'hC || imem_addr !== 32'hC) begin bad++; $display("FAIL third got pc4=%h a=%h exp c/c", ifid_pc4, imem_addr); end
    endtask

    task automatic test_stall();
        tick();
        total++; if (imem_addr !== 32'h10 || ifid_pc4 !== 32'h10) begin bad++; $display("FAIL pre_stall got a=%h pc4=%h exp 10/10", imem_addr, ifid_pc4); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_addr !== 32'h10 || ifid_pc4 !== 32'h10 || ifid_instr !== 32'h1000_000C || ifid_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got a=%h pc4=%h i=%h v=%b", i, imem_addr, ifid_pc4, ifid_instr, ifid_valid);
            end
        end
`ifdef IF_STAGE_PERF_EN
        total++; if (perf_stall_cycles !== 32'd3) begin bad++; $display("FAIL perf got=%0d exp=3", perf_stall_cycles); end
`endif
        stall = 1'b0;
        tick();
        total++; if (ifid_pc4 !== 32'h14 || ifid_instr !== 32'h1000_0010 || imem_addr !== 32'h14) begin bad++; $display("FAIL resume got pc4=%h i=%h a=%h", ifid_pc4, ifid_instr, imem_addr); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h47; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        total++; if (imem_addr !== 32'h44 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0) begin bad++; $display("FAIL redir_bubble got a=%h v=%b pc4=%h exp 44/0/0", imem_addr, ifid_valid, ifid_pc4); end
        tick();
        total++; if (ifid_pc4 !== 32'h48 || ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0044) begin bad++; $display("FAIL redir_target got pc4=%h v=%b i=%h", ifid_pc4, ifid_valid, ifid_instr); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem_addr !== 32'h4C) begin bad++; $display("FAIL flush got v=%b i=%h a=%h exp 0/0/4c", ifid_valid, ifid_instr, imem_addr); end
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h50) begin bad++; $display("FAIL post_flush got v=%b pc4=%h exp 1/50", ifid_valid, ifid_pc4); end
    endtask

    task automatic test_halt();
        halt_en = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h18;
        tick();
        redirect = 1'b0;
        tick(); tick();
        total++; if (imem_addr !== 32'h20 || halted !== 1'b0) begin bad++; $display("FAIL pre_halt got a=%h h=%b exp 20/0", imem_addr, halted); end
        tick();
        total++; if (ifid_instr !== 32'hFFFF_FFFF || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h24) begin bad++; $display("FAIL halt_word got i=%h v=%b pc4=%h", ifid_instr, ifid_valid, ifid_pc4); end
        total++; if (halted !== 1'b1 || imem_addr !== 32'h20) begin bad++; $display("FAIL halt_state got h=%b a=%h exp 1/20", halted, imem_addr); end
        redirect = 1'b1; redirect_pc = 32'h100; flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (imem_addr !== 32'h20 || halted !== 1'b1 || ifid_valid !== 1'b0) begin bad++; $display("FAIL halt_frozen%0d got a=%h h=%b v=%b", i, imem_addr, halted, ifid_valid); end
        end
        redirect = 1'b0; flush = 1'b0; halt_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #4 reset = 1'b1;
        tick();  // BOOT
        for (int i = 0; i < 12; i++) tick();
        total++; if (imem_addr !== 32'h30 || ifid_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got a=%h v=%b exp 30/1", imem_addr, ifid_valid); end
        #2 reset = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || halted !== 1'b0) begin
            bad++; $display("FAIL mid_reset got a=%h v=%b i=%h pc4=%h h=%b", imem_addr, ifid_valid, ifid_instr, ifid_pc4, halted);
        end
`ifdef IF_STAGE_PERF_EN
        total++; if (perf_stall_cycles !== 32'd0) begin bad++; $display("FAIL mid_perf got=%0d exp=0", perf_stall_cycles); end
`endif
    endtask

    task automatic test_wrap();
        @(negedge clk);
        reset = 1'b1;
        tick();  // BOOT
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        tick();
        total++; if (ifid_pc4 !== 32'h0 || ifid_instr !== 32'hFFFF_FFFC || imem_addr !== 32'h0 || ifid_valid !== 1'b1) begin
            bad++; $display("FAIL wrap got pc4=%h i=%h a=%h v=%b exp 0/fffffffc/0/1", ifid_pc4, ifid_instr, imem_addr, ifid_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_flush();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
